// File: rtl/clk_div_top.sv
// Programmable divider: a WIDTH-bit counter wraps at a shadowed terminal value and toggles count_out.
// Define CLK_DIV_PULSE_EN to make count_out a one-cycle pulse per wrap instead of a toggle.
module clk_div_top #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:0]       start,
  input  logic [WIDTH-1:0] final_val,
  output logic [0:0]       count_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] term_reg;
  logic             wrap;

  assign wrap = (cnt == term_reg);

  // term_reg is only reloaded at run entry and at each wrap, so a new final_val never cuts a period short
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      term_reg  <= '0;
      count_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef CLK_DIV_PULSE_EN
          count_out <= 1'b0;
`endif
          if (start[0]) begin
            state    <= RUN;
            term_reg <= final_val;
          end
        end
        RUN: begin
          if (!start[0]) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef CLK_DIV_PULSE_EN
            count_out <= 1'b0;
`endif
          end else if (wrap) begin
            cnt      <= '0;
            term_reg <= final_val;
`ifdef CLK_DIV_PULSE_EN
            count_out <= 1'b1;
`else
            count_out <= ~count_out;
`endif
          end else begin
            cnt <= cnt + 1'b1;
`ifdef CLK_DIV_PULSE_EN
            count_out <= 1'b0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_top.sv
// Directed bench for clk_div_top: reset, divide ratios, shadowed terminal value, pause and async reset.
module tb_clk_div_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] start;
  logic [9:0] final_val;
  logic [0:0] count_out;

  int total = 0;
  int bad   = 0;

  clk_div_top #(.WIDTH(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .final_val(final_val),
    .count_out(count_out)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 5 ns after each rising edge
  task automatic step();
    @(posedge clk);
    #5;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, "_async_co"}, 16'(count_out), 16'd0);
    chk({tag, "_async_cnt"}, 16'(dut.cnt), 16'd0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    final_val = 10'd2;
    #5;
    chk("rst_co", 16'(count_out), 16'd0);
    chk("rst_cnt", 16'(dut.cnt), 16'd0);
    step();
    step();
    chk("rst_hold_co", 16'(count_out), 16'd0);
    chk("rst_hold_cnt", 16'(dut.cnt), 16'd0);

`ifdef CLK_DIV_PULSE_EN
    // final=3: one-cycle pulse after every 4th edge past entry
    reset     = 1'b0;
    final_val = 10'd3;
    start     = 1'b1;
    step();
    chk("pulse_entry", 16'(count_out), 16'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("pulse_k%0d", k), 16'(count_out), 16'((k % 4) == 0));
    end
    for (int k = 1; k <= 4; k++) step();
    chk("pulse_pre_rst", 16'(count_out), 16'd1);
    do_reset("pulse_rst");
    start = 1'b0;
    step();
    chk("pulse_idle", 16'(count_out), 16'd0);
`else
    // final=2: toggle every 3 edges, first one 3 edges after entry
    reset = 1'b0;
    start = 1'b1;
    step();
    chk("div3_entry", 16'(count_out), 16'd0);
    chk("div3_entry_cnt", 16'(dut.cnt), 16'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("div3_k%0d", k), 16'(count_out), 16'(((k / 3) % 2) == 1));
    end

    // count_out is high here; reset between edges must clear it without a clock
    do_reset("div3_rst");

    // final=0: divide-by-2
    final_val = 10'd0;
    start     = 1'b1;
    step();
    chk("div2_entry", 16'(count_out), 16'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("div2_k%0d", k), 16'(count_out), 16'(k % 2));
    end

    // final 2 -> 5 mid-period: first half-period still 3, then 6
    do_reset("chg_rst");
    final_val = 10'd2;
    start     = 1'b1;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 1) final_val = 10'd5;
      chk($sformatf("chg_k%0d", k), 16'(count_out),
          16'((k >= 3) && ((((k - 3) / 6) % 2) == 0)));
    end

    // pause: final=3, toggle at k=4, pause 5 cycles, restart needs 4 more edges
    do_reset("pause_rst");
    final_val = 10'd3;
    start     = 1'b1;
    step();
    for (int k = 1; k <= 6; k++) step();
    chk("pause_pre", 16'(count_out), 16'd1);
    chk("pause_pre_cnt", 16'(dut.cnt), 16'd2);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("pause_hold%0d", k), 16'(count_out), 16'd1);
    end
    chk("pause_cnt", 16'(dut.cnt), 16'd0);
    start = 1'b1;
    step();
    chk("pause_reentry", 16'(count_out), 16'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("pause_run%0d", k), 16'(count_out), 16'(k < 4));
    end

    // full-range terminal value is captured without truncation
    do_reset("max_rst");
    final_val = 10'h3FF;
    start     = 1'b1;
    step();
    for (int k = 1; k <= 1023; k++) step();
    chk("max_cnt", 16'(dut.cnt), 16'h3FF);
    chk("max_pre", 16'(count_out), 16'd0);
    step();
    chk("max_wrap", 16'(count_out), 16'd1);
    chk("max_wrap_cnt", 16'(dut.cnt), 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
